// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the keypad scanner and its downstream
// symbol decoder.
//   scan_state_e : debounce state machine encoding
//   scan_class_e : classification of one complete matrix scan
//   SYM_*        : keypad symbols produced by the downstream decoder
//   raw_to_sym   : maps a row-major raw code from a 4x4 pad to a symbol
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_class_e;

  localparam int SYM_W = 5;
  localparam logic [SYM_W-1:0] SYM_0         = 5'd0;
  localparam logic [SYM_W-1:0] SYM_1         = 5'd1;
  localparam logic [SYM_W-1:0] SYM_2         = 5'd2;
  localparam logic [SYM_W-1:0] SYM_3         = 5'd3;
  localparam logic [SYM_W-1:0] SYM_4         = 5'd4;
  localparam logic [SYM_W-1:0] SYM_5         = 5'd5;
  localparam logic [SYM_W-1:0] SYM_6         = 5'd6;
  localparam logic [SYM_W-1:0] SYM_7         = 5'd7;
  localparam logic [SYM_W-1:0] SYM_8         = 5'd8;
  localparam logic [SYM_W-1:0] SYM_9         = 5'd9;
  localparam logic [SYM_W-1:0] SYM_BACKSPACE = 5'd10;
  localparam logic [SYM_W-1:0] SYM_ENTER     = 5'd11;
  localparam logic [SYM_W-1:0] SYM_PAUSE     = 5'd12;
  localparam logic [SYM_W-1:0] SYM_SWITCH    = 5'd13;
  localparam logic [SYM_W-1:0] SYM_NO_KEY    = 5'd31;

  // Board layout (row-major):  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  // A = pause, B = switch, * = backspace, # = enter, C and D unused.
  function automatic logic [SYM_W-1:0] raw_to_sym(input logic [3:0] raw);
    logic [SYM_W-1:0] sym;
    case (raw)
      4'd0:    sym = SYM_1;
      4'd1:    sym = SYM_2;
      4'd2:    sym = SYM_3;
      4'd3:    sym = SYM_PAUSE;
      4'd4:    sym = SYM_4;
      4'd5:    sym = SYM_5;
      4'd6:    sym = SYM_6;
      4'd7:    sym = SYM_SWITCH;
      4'd8:    sym = SYM_7;
      4'd9:    sym = SYM_8;
      4'd10:   sym = SYM_9;
      4'd12:   sym = SYM_BACKSPACE;
      4'd13:   sym = SYM_0;
      4'd14:   sym = SYM_ENTER;
      default: sym = SYM_NO_KEY;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer
// Column dwell divider and column strobe generator.
//   clk, rst_n : clock and synchronous active-low reset
//   col_idx    : zero-based column currently driven (column 1 = index 0)
//   col_out    : registered active-low one-cold strobe, col_out[COLS-1] = column 1
//   tick       : last cycle of the current column's dwell (rows sampled here)
//   scan_done  : tick of the last column, i.e. a full scan is complete
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 62501,
  parameter int COL_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COL_W-1:0] col_idx,
  output logic [COLS-1:0]  col_out,
  output logic             tick,
  output logic             scan_done
);

  localparam int               DIV_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(COLS - 1);
  localparam logic [COLS-1:0]  COL_OUT_RST = ~(COLS'(1) << (COLS - 1));

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [COLS-1:0]  col_out_q, col_out_d;
  logic             tick_s;
  logic             scan_done_s;

  // Divider, column advance and the strobe pattern for the next column.
  always_comb begin
    tick_s      = (div_cnt_q == DIV_LAST);
    scan_done_s = tick_s && (col_idx_q == COL_LAST);
    if (tick_s) begin
      div_cnt_d = '0;
      if (col_idx_q == COL_LAST) begin
        col_idx_d = '0;
      end else begin
        col_idx_d = col_idx_q + 1'b1;
      end
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
      col_idx_d = col_idx_q;
    end
    // Strobe is derived from the next index so col_out and col_idx move together.
    col_out_d                       = '1;
    col_out_d[COL_LAST - col_idx_d] = 1'b0;
  end

  // State registers with synchronous reset to column 1 driven.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      col_idx_q <= '0;
      col_out_q <= COL_OUT_RST;
    end else begin
      div_cnt_q <= div_cnt_d;
      col_idx_q <= col_idx_d;
      col_out_q <= col_out_d;
    end
  end

  assign col_idx   = col_idx_q;
  assign col_out   = col_out_q;
  assign tick      = tick_s;
  assign scan_done = scan_done_s;

endmodule

// File: rtl/keypad_scan_matrix.sv
// keypad_scan_matrix
// Scans a ROWS x COLS key matrix, debounces by whole-scan agreement and
// emits one-cycle key events carrying a row-major raw code.
//   clk, rst_n : clock and synchronous active-low reset
//   row_in     : active-low row sense, row_in[ROWS-1] = row 1
//   col_out    : active-low one-cold column strobe, col_out[COLS-1] = column 1
//   key_valid  : one-cycle pulse when a key is accepted (or auto-repeated)
//   key_code   : row_idx*COLS + col_idx of the last accepted key, held
//   key_held   : high while the accepted key remains pressed
//   multi_key  : high for the scan period after a scan with >1 closed contact
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid while
// the accepted key is held (REPEAT_DELAY scans, then every REPEAT_RATE scans).
module keypad_scan_matrix
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 62501,
  parameter int STABLE_SCANS = 2,
  parameter int CODE_W       = $clog2(ROWS * COLS)
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              multi_key
);

  localparam int               COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int               CNT_W      = $clog2(STABLE_SCANS + 1);
  localparam logic [CNT_W-1:0] STABLE_N   = CNT_W'(STABLE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               STABLE_ONE = (STABLE_SCANS <= 1);

  logic [COL_W-1:0] col_idx_s;
  logic             tick_s;
  logic             scan_done_s;

  // snap[c][r] = 1 when the contact at row_idx r / col_idx c is closed.
  logic [COLS-1:0][ROWS-1:0] snap_q, snap_d;
  logic [1:0]                n_closed_s;
  logic [CODE_W-1:0]         hit_code_s;
  scan_class_e               cls_s;

  scan_state_e       state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;
  logic              accept_s;
  logic              release_s;
  logic              rep_pulse_s;

  keypad_scan_timer #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .COL_W    (COL_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_idx   (col_idx_s),
    .col_out   (col_out),
    .tick      (tick_s),
    .scan_done (scan_done_s)
  );

  // Snapshot update and full-scan classification (uses the freshly sampled column).
  always_comb begin
    snap_d = snap_q;
    if (tick_s) begin
      for (int r = 0; r < ROWS; r++) begin
        snap_d[col_idx_s][r] = ~row_in[ROWS-1-r];
      end
    end else begin
      snap_d = snap_q;
    end
    n_closed_s = 2'd0;
    hit_code_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (snap_d[c][r]) begin
          if (n_closed_s != 2'd2) begin
            n_closed_s = n_closed_s + 2'd1;
          end else begin
            n_closed_s = 2'd2;
          end
          hit_code_s = CODE_W'(r * COLS + c);
        end else begin
          n_closed_s = n_closed_s;
        end
      end
    end
    case (n_closed_s)
      2'd0:    cls_s = EMPTY;
      2'd1:    cls_s = SINGLE;
      default: cls_s = MULTI;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int               REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int               REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_N = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] RATE_N  = REP_W'(REPEAT_RATE);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;

  // Repeat counter: counts scans of the accepted key while in HELD; any other
  // scan outcome either leaves HELD or interrupts the hold, so it restarts.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_pulse_s = 1'b0;
    if (state_q != HELD) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (scan_done_s) begin
      if ((cls_s == SINGLE) && (hit_code_s == key_code_q)) begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        if (rep_cnt_d == (rep_first_q ? DELAY_N : RATE_N)) begin
          rep_pulse_s = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_pulse_s = 1'b0;
        end
      end else begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
  end

  // Repeat counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_pulse_s = 1'b0;
`endif

  // Debounce state machine: next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = rep_pulse_s;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    accept_s    = 1'b0;
    release_s   = 1'b0;
    if (scan_done_s) begin
      multi_key_d = (cls_s == MULTI);
      case (state_q)
        IDLE: begin
          if (cls_s == SINGLE) begin
            cand_d = hit_code_s;
            cnt_d  = CNT_ONE;
            if (STABLE_ONE) begin
              accept_s = 1'b1;
            end else begin
              state_d = PRESS_PEND;
            end
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_PEND: begin
          if ((cls_s == SINGLE) && (hit_code_s == cand_q)) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d >= STABLE_N) begin
              accept_s = 1'b1;
            end else begin
              accept_s = 1'b0;
            end
          end else if (cls_s == SINGLE) begin
            cand_d = hit_code_s;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          // MULTI counts as empty, so only a single contact keeps the key held.
          if (cls_s != SINGLE) begin
            cnt_d = CNT_ONE;
            if (STABLE_ONE) begin
              release_s = 1'b1;
            end else begin
              state_d = REL_PEND;
            end
          end else begin
            state_d = HELD;
          end
        end
        REL_PEND: begin
          if (cls_s != SINGLE) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d >= STABLE_N) begin
              release_s = 1'b1;
            end else begin
              release_s = 1'b0;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (accept_s) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        state_d     = HELD;
        cnt_d       = '0;
      end else if (release_s) begin
        key_held_d = 1'b0;
        state_d    = IDLE;
        cnt_d      = '0;
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Debounce registers with synchronous reset discarding all partial state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q      <= '0;
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_matrix.sv
// tb_keypad_scan_matrix
// Self-checking bench: a 4x4 key pad is emulated from col_out and a set of
// pressed keys; a scan-level reference model (run lengths of identical scan
// outcomes) predicts key_valid / key_code / key_held / multi_key / col_out.
// Honours KEYPAD_AUTOREPEAT_EN for the auto-repeat expectations.
module tb_keypad_scan_matrix;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int SCAN_DIV     = 4;
  localparam int STABLE_SCANS = 2;
  localparam int NKEYS        = ROWS * COLS;
  localparam int SCAN_LEN     = COLS * SCAN_DIV;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RDELAY = 8;
  localparam int RRATE  = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [ROWS-1:0]  row_in;
  logic [COLS-1:0]  col_out;
  logic             key_valid;
  logic [3:0]       key_code;
  logic             key_held;
  logic             multi_key;
  logic [NKEYS-1:0] key_down;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int pulses = 0;

  // Reference model state
  int run_val;
  int run_len;
  bit acc_in_run;
  bit m_held;
  int m_code;
  bit exp_valid;
  bit exp_multi;

  always #5 clk = ~clk;

  keypad_scan_matrix #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .SCAN_DIV     (SCAN_DIV),
    .STABLE_SCANS (STABLE_SCANS)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (RDELAY),
    .REPEAT_RATE  (RRATE)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  // Passive key matrix: a pressed key shorts its column strobe onto its row.
  always_comb begin
    row_in = '1;
    for (int c = 0; c < COLS; c++) begin
      if (col_out[COLS-1-c] == 1'b0) begin
        for (int r = 0; r < ROWS; r++) begin
          if (key_down[r*COLS+c]) row_in[ROWS-1-r] = 1'b0;
        end
      end
    end
  end

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    run_val    = -1;
    run_len    = 0;
    acc_in_run = 1'b0;
    m_held     = 1'b0;
    m_code     = 0;
    exp_valid  = 1'b0;
    exp_multi  = 1'b0;
  endtask

  // One full scan outcome: a single closed key has value = its code, anything else is "empty".
  task automatic model_scan(input logic [NKEYS-1:0] keys);
    int nk;
    int v;
    int s;
    nk = $countones(keys);
    exp_multi = (nk > 1);
    v = -1;
    if (nk == 1) begin
      for (int i = 0; i < NKEYS; i++) if (keys[i]) v = i;
    end
    if (v == run_val) begin
      run_len++;
    end else begin
      run_val = v; run_len = 1; acc_in_run = 1'b0;
    end
    exp_valid = 1'b0;
    if (!m_held) begin
      if (v >= 0 && run_len >= STABLE_SCANS) begin
        m_held = 1'b1; m_code = v; exp_valid = 1'b1; acc_in_run = 1'b1;
      end
    end else if (v < 0) begin
      if (run_len >= STABLE_SCANS) m_held = 1'b0;
    end else begin
      s = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (v == m_code) begin
        s = acc_in_run ? run_len - STABLE_SCANS : run_len;
        if (s >= RDELAY && ((s - RDELAY) % RRATE) == 0) exp_valid = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [COLS-1:0] exp_col;
    int col;
    col = (cyc / SCAN_DIV) % COLS;
    exp_col = '1;
    exp_col[COLS-1-col] = 1'b0;
    check_val({tag, "_col_out"}, col_out, exp_col);
    check_val({tag, "_key_valid"}, key_valid, exp_valid);
    check_val({tag, "_key_held"}, key_held, m_held);
    check_val({tag, "_multi_key"}, multi_key, exp_multi);
    check_val({tag, "_key_code"}, key_code, m_code);
    if (key_valid === 1'b1) pulses++;
  endtask

  // Advance one clock; the model is updated on the edge that completes a scan.
  task automatic step();
    @(posedge clk);
    cyc++;
    if ((cyc % SCAN_LEN) == 0) model_scan(key_down);
    else exp_valid = 1'b0;
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic run_scan(input logic [NKEYS-1:0] keys);
    key_down = keys;
    repeat (SCAN_LEN) step();
  endtask

  task automatic run_partial(input logic [NKEYS-1:0] keys, input int n);
    key_down = keys;
    repeat (n) step();
  endtask

  // Called at a negedge (or time 0); leaves the bench at the negedge after release.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    model_reset();
    check_outputs("reset");
    check_val("reset_col_out_0111", col_out, 4'b0111);
  endtask

  function automatic logic [NKEYS-1:0] one_key(input int code);
    logic [NKEYS-1:0] k;
    k = '0;
    k[code] = 1'b1;
    return k;
  endfunction

  initial begin
    int p0;
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] prev;
    int r;
    key_down = '0;
    rst_n    = 1'b0;
    model_reset();

    // Reset and idle column cycling
    do_reset(3);
    p0 = pulses;
    repeat (2) run_scan('0);
    check_val("idle_pulses", pulses - p0, 0);

    // Clean press of key "2" (row 1, column 2 -> code 1)
    p0 = pulses;
    repeat (4) run_scan('0);
    repeat (4) run_scan(one_key(1));
    check_val("press_key_code", key_code, 1);
    check_val("press_held", key_held, 1);
    run_scan('0);
    check_val("held_after_1_empty", key_held, 1);
    run_scan('0);
    check_val("released_after_2_empty", key_held, 0);
    check_val("press_pulses", pulses - p0, 1);

    // Bounce: present, absent, present, present
    p0 = pulses;
    run_scan(one_key(6));
    run_scan('0);
    run_scan(one_key(6));
    check_val("bounce_no_early", pulses - p0, 0);
    run_scan(one_key(6));
    check_val("bounce_pulses", pulses - p0, 1);
    check_val("bounce_code", key_code, 6);
    repeat (3) run_scan('0);

    // Two keys: row1/col1 (code 0) and row2/col2 (code 5)
    p0 = pulses;
    repeat (2) run_scan(one_key(0) | one_key(5));
    check_val("two_keys_multi", multi_key, 1);
    check_val("two_keys_no_event", pulses - p0, 0);
    repeat (2) run_scan(one_key(5));
    check_val("two_keys_multi_clear", multi_key, 0);
    check_val("two_keys_pulses", pulses - p0, 1);
    check_val("two_keys_code", key_code, 5);
    repeat (3) run_scan('0);

    // Reset in the middle of a press debounce
    p0 = pulses;
    run_scan(one_key(9));
    run_partial(one_key(9), 6);
    do_reset(1);
    run_scan(one_key(9));
    check_val("midrst_no_event", pulses - p0, 0);
    run_scan(one_key(9));
    check_val("midrst_pulses", pulses - p0, 1);
    repeat (3) run_scan('0);

    // Long hold: auto-repeat when enabled, single event otherwise
    p0 = pulses;
    repeat (14) run_scan(one_key(14));
`ifdef KEYPAD_AUTOREPEAT_EN
    check_val("hold14_pulses", pulses - p0, 4);
`else
    check_val("hold14_pulses", pulses - p0, 1);
`endif
    repeat (3) run_scan('0);

    // Randomised scans with occasional mid-scan resets
    prev = '0;
    for (int it = 0; it < 160; it++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        run_partial(one_key($urandom_range(0, NKEYS-1)), $urandom_range(1, SCAN_LEN-2));
        do_reset($urandom_range(1, 3));
        prev = '0;
      end else begin
        if (r < 50) begin
          keys = prev;
        end else begin
          case ($urandom_range(0, 3))
            0:       keys = '0;
            1, 2:    keys = one_key($urandom_range(0, NKEYS-1));
            default: keys = one_key($urandom_range(0, NKEYS-1)) | one_key($urandom_range(0, NKEYS-1));
          endcase
        end
        run_scan(keys);
        prev = keys;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
